// File: rtl/wb_arbiter_if.sv
// GRF write-port bundle for wb_arbiter: pipeline writeback, MDU issue/result
// handshake and the committed GRF write plus the pending scoreboard.
interface wb_arbiter_if #(
    parameter int PTR_W = 2
);
    logic             pipe_we;
    logic [4:0]       pipe_addr;
    logic [31:0]      pipe_data;
    logic [31:0]      pipe_pc;
    logic             mdu_issue;
    logic [4:0]       mdu_issue_addr;
    logic             mdu_valid;
    logic             mdu_ready;
    logic [4:0]       mdu_addr;
    logic [31:0]      mdu_data;
    logic [31:0]      mdu_pc;
    logic             RegWr;
    logic [4:0]       RWAddr;
    logic [31:0]      RWData;
    logic [31:0]      PC;
    logic [31:0]      pending;
    logic [PTR_W:0]   fifo_count;

    // slave: the arbiter; master: whoever drives writebacks and MDU results
    modport slave (
        input  pipe_we, pipe_addr, pipe_data, pipe_pc,
        input  mdu_issue, mdu_issue_addr,
        input  mdu_valid, mdu_addr, mdu_data, mdu_pc,
        output mdu_ready,
        output RegWr, RWAddr, RWData, PC, pending, fifo_count
    );

    modport master (
        output pipe_we, pipe_addr, pipe_data, pipe_pc,
        output mdu_issue, mdu_issue_addr,
        output mdu_valid, mdu_addr, mdu_data, mdu_pc,
        input  mdu_ready,
        input  RegWr, RWAddr, RWData, PC, pending, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// GRF write-port arbiter: pipeline writebacks win, MDU results queue in a FIFO.
// Define WB_TRACE_EN to print every nonzero-address commit.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic           clk,
    input  logic           Reset,
    wb_arbiter_if.slave    bus
);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t           fifo_q [FIFO_DEPTH];
    entry_t           fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             regwr_q, regwr_d;
    logic [4:0]       rwaddr_q, rwaddr_d;
    logic [31:0]      rwdata_q, rwdata_d;
    logic [31:0]      rwpc_q, rwpc_d;
    logic [31:0]      pending_q, pending_d;

    logic   full;
    logic   push;
    logic   pop;
    entry_t head;

    // mdu_ready comes from the registered count only, so a full FIFO never
    // accepts even when the same cycle pops.
    assign full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign push = bus.mdu_valid && !full;
    assign pop  = !bus.pipe_we && (count_q != '0);
    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        regwr_d   = 1'b0;
        rwaddr_d  = rwaddr_q;
        rwdata_d  = rwdata_q;
        rwpc_d    = rwpc_q;
        pending_d = pending_q;

        if (bus.pipe_we) begin
            regwr_d  = (bus.pipe_addr != 5'd0);
            rwaddr_d = bus.pipe_addr;
            rwdata_d = bus.pipe_data;
            rwpc_d   = bus.pipe_pc;
        end else if (pop) begin
            regwr_d  = (head.addr != 5'd0);
            rwaddr_d = head.addr;
            rwdata_d = head.data;
            rwpc_d   = head.pc;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            pending_d[head.addr] = 1'b0;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = '{addr: bus.mdu_addr, data: bus.mdu_data, pc: bus.mdu_pc};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // A fresh issue to the register being retired means a newer op is still out.
        if (bus.mdu_issue)
            pending_d[bus.mdu_issue_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            regwr_q   <= 1'b0;
            rwaddr_q  <= '0;
            rwdata_q  <= '0;
            rwpc_q    <= '0;
            pending_q <= '0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            regwr_q   <= regwr_d;
            rwaddr_q  <= rwaddr_d;
            rwdata_q  <= rwdata_d;
            rwpc_q    <= rwpc_d;
            pending_q <= pending_d;
`ifdef WB_TRACE_EN
            if (regwr_d)
                $display("%s @%h: $%d <= %h", bus.pipe_we ? "P" : "M", rwpc_d, rwaddr_d, rwdata_d);
`endif
        end
    end

    assign bus.mdu_ready  = !full;
    assign bus.RegWr      = regwr_q;
    assign bus.RWAddr     = rwaddr_q;
    assign bus.RWData     = rwdata_q;
    assign bus.PC         = rwpc_q;
    assign bus.pending    = pending_q;
    assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: reference model feeds an expected-commit queue that is
// drained and compared whenever the GRF port shows a write.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    logic clk;
    logic Reset;

    wb_arbiter_if #(.PTR_W(2)) bus ();

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    ent_t        mq[$];
    ent_t        exp_q[$];
    logic [31:0] m_pend;
    logic        m_regwr;
    logic        m_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: predict the commit from the driven inputs, then
    // compare every observable output just after the edge.
    task automatic cycle();
        ent_t e;
        logic push;
        logic pop;
        m_acc = 1'b0;
        if (Reset) begin
            mq.delete();
            exp_q.delete();
            m_pend  = '0;
            m_regwr = 1'b0;
        end else begin
            push    = bus.mdu_valid && (mq.size() < DEPTH);
            pop     = !bus.pipe_we && (mq.size() > 0);
            m_regwr = 1'b0;
            if (bus.pipe_we) begin
                if (bus.pipe_addr != 5'd0) begin
                    exp_q.push_back('{bus.pipe_addr, bus.pipe_data, bus.pipe_pc});
                    m_regwr = 1'b1;
                end
            end else if (pop) begin
                e = mq.pop_front();
                m_pend[e.a] = 1'b0;
                if (e.a != 5'd0) begin
                    exp_q.push_back(e);
                    m_regwr = 1'b1;
                end
            end
            if (push) begin
                mq.push_back('{bus.mdu_addr, bus.mdu_data, bus.mdu_pc});
                m_acc = 1'b1;
            end
            if (bus.mdu_issue)
                m_pend[bus.mdu_issue_addr] = 1'b1;
            m_pend[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("regwr", 64'(bus.RegWr), 64'(m_regwr));
        if (bus.RegWr && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rwaddr", 64'(bus.RWAddr), 64'(e.a));
            chk("rwdata", 64'(bus.RWData), 64'(e.d));
            chk("pc",     64'(bus.PC),     64'(e.p));
        end
        chk("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
        chk("mdu_ready",  64'(bus.mdu_ready),  64'(mq.size() < DEPTH));
        chk("pending",    64'(bus.pending),    64'(m_pend));
    endtask

    task automatic idle_inputs();
        bus.pipe_we = 0; bus.pipe_addr = 0; bus.pipe_data = 0; bus.pipe_pc = 0;
        bus.mdu_issue = 0; bus.mdu_issue_addr = 0;
        bus.mdu_valid = 0; bus.mdu_addr = 0; bus.mdu_data = 0; bus.mdu_pc = 0;
    endtask

    task automatic push_mdu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        bus.mdu_valid = 1; bus.mdu_addr = a; bus.mdu_data = d; bus.mdu_pc = p;
    endtask

    task automatic drive_pipe(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        bus.pipe_we = 1; bus.pipe_addr = a; bus.pipe_data = d; bus.pipe_pc = p;
    endtask

    initial begin
        int g;
        m_pend  = '0;
        m_regwr = 1'b0;
        m_acc   = 1'b0;
        idle_inputs();

        // reset then idle
        Reset = 1;
        cycle();
        Reset = 0;
        chk("rst_regwr",  64'(bus.RegWr), 64'd0);
        chk("rst_rwaddr", 64'(bus.RWAddr), 64'd0);
        chk("rst_rwdata", 64'(bus.RWData), 64'd0);
        chk("rst_pc",     64'(bus.PC), 64'd0);
        chk("rst_pend",   64'(bus.pending), 64'd0);
        chk("rst_ready",  64'(bus.mdu_ready), 64'd1);
        chk("rst_count",  64'(bus.fifo_count), 64'd0);
        cycle();

        // single MDU op: issue in cycle 0, result pushed in cycle 3, visible in cycle 5
        bus.mdu_issue = 1; bus.mdu_issue_addr = 5'd8;
        cycle();
        bus.mdu_issue = 0;
        chk("pend8_set", 64'(bus.pending[8]), 64'd1);
        cycle();
        cycle();
        push_mdu(5'd8, 32'h0000ABCD, 32'h0000_0100);
        cycle();
        bus.mdu_valid = 0;
        chk("single_not_yet", 64'(bus.RegWr), 64'd0);
        cycle();
        chk("single_regwr", 64'(bus.RegWr), 64'd1);
        chk("single_addr",  64'(bus.RWAddr), 64'd8);
        chk("single_data",  64'(bus.RWData), 64'h0000ABCD);
        chk("pend8_clr",    64'(bus.pending[8]), 64'd0);
        cycle();

        // pipeline priority over a queued MDU result
        bus.mdu_issue = 1; bus.mdu_issue_addr = 5'd9;
        cycle();
        bus.mdu_issue = 0;
        push_mdu(5'd9, 32'h9999_0009, 32'h0000_0200);
        drive_pipe(5'd10, 32'hA0A0_0010, 32'h0000_0300);
        cycle();
        bus.mdu_valid = 0;
        chk("prio_count1", 64'(bus.fifo_count), 64'd1);
        drive_pipe(5'd11, 32'hA0A0_0011, 32'h0000_0304);
        cycle();
        drive_pipe(5'd12, 32'hA0A0_0012, 32'h0000_0308);
        cycle();
        chk("prio_count3", 64'(bus.fifo_count), 64'd1);
        bus.pipe_we = 0;
        cycle();
        chk("prio_mdu_addr", 64'(bus.RWAddr), 64'd9);
        cycle();

        // full FIFO: four accepted behind pipeline traffic, fifth held until a pop
        for (int i = 1; i <= 4; i++) begin
            drive_pipe(5'd20, 32'hB000_0000 + 32'(i), 32'h0000_0400 + 32'(4*i));
            push_mdu(5'(i), 32'h1000_0000 + 32'(i), 32'h0000_0500 + 32'(4*i));
            cycle();
        end
        chk("full_ready", 64'(bus.mdu_ready), 64'd0);
        push_mdu(5'd5, 32'h1000_0005, 32'h0000_0514);
        cycle();
        cycle();
        chk("full_held", 64'(bus.fifo_count), 64'd4);
        bus.pipe_we = 0;
        g = 0;
        do begin
            cycle();
            g++;
        end while (!m_acc && g < 10);
        bus.mdu_valid = 0;
        repeat (8) cycle();
        chk("full_drained", 64'(bus.fifo_count), 64'd0);

        // write to $0 is popped but never reaches the GRF
        push_mdu(5'd0, 32'hDEAD_BEEF, 32'h0000_0600);
        cycle();
        bus.mdu_valid = 0;
        chk("zero_queued", 64'(bus.fifo_count), 64'd1);
        cycle();
        chk("zero_popped", 64'(bus.fifo_count), 64'd0);
        chk("zero_regwr",  64'(bus.RegWr), 64'd0);
        cycle();

        // set/clear collision on register 5
        bus.mdu_issue = 1; bus.mdu_issue_addr = 5'd5;
        cycle();
        bus.mdu_issue = 0;
        push_mdu(5'd5, 32'h5555_0005, 32'h0000_0700);
        cycle();
        bus.mdu_valid = 0;
        bus.mdu_issue = 1; bus.mdu_issue_addr = 5'd5;
        cycle();
        bus.mdu_issue = 0;
        chk("coll_regwr", 64'(bus.RegWr), 64'd1);
        chk("coll_pend5", 64'(bus.pending[5]), 64'd1);
        cycle();

        // reset with three results queued
        for (int i = 0; i < 3; i++) begin
            drive_pipe(5'd3, 32'hC000_0000 + 32'(i), 32'h0000_0800 + 32'(4*i));
            push_mdu(5'(13 + i), 32'hD000_0000 + 32'(i), 32'h0000_0900 + 32'(4*i));
            bus.mdu_issue = 1; bus.mdu_issue_addr = 5'(13 + i);
            cycle();
        end
        idle_inputs();
        chk("pre_rst_count", 64'(bus.fifo_count), 64'd3);
        Reset = 1;
        cycle();
        Reset = 0;
        chk("rst_mid_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_mid_pend",  64'(bus.pending), 64'd0);
        repeat (4) cycle();

        // random traffic against the model, with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            bus.pipe_we        = ($urandom_range(0, 2) == 0);
            bus.pipe_addr      = 5'($urandom_range(0, 31));
            bus.pipe_data      = $urandom;
            bus.pipe_pc        = $urandom;
            bus.mdu_issue      = ($urandom_range(0, 3) == 0);
            bus.mdu_issue_addr = 5'($urandom_range(0, 31));
            bus.mdu_valid      = ($urandom_range(0, 1) == 0);
            bus.mdu_addr       = 5'($urandom_range(0, 31));
            bus.mdu_data       = $urandom;
            bus.mdu_pc         = $urandom;
            Reset              = (i == 200);
            cycle();
        end
        Reset = 0;
        idle_inputs();
        repeat (8) cycle();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "bench timeout");
    end

endmodule
